// File: rtl/tetris_lcd_renderer.sv
// Raster renderer for the Tetris LCD: walks the panel, overlays the snapshotted falling
// piece on the locked board and streams RGB565 pixels over a valid/ready handshake.
module tetris_lcd_renderer #(
   parameter int LCD_W    = 240,
   parameter int LCD_H    = 240,
   parameter int CELL_PX  = 16,
   parameter int BOARD_X0 = 40,
   parameter int BOARD_Y0 = 24
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        lcd_ready,
   output logic        frame_start,
   output logic [4:0]  q_x,
   output logic [4:0]  q_y,
   input  logic [3:0]  q_color,
   input  logic [2:0]  cur_shape,
   input  logic [1:0]  cur_rot,
   input  logic [4:0]  cur_x,
   input  logic [5:0]  cur_y,
   input  logic [3:0]  cur_color,
   output logic [15:0] pix_data,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        pix_first,
   output logic        pix_last
);
   localparam int          SH   = $clog2(CELL_PX);
   localparam logic [15:0] BX0  = 16'(BOARD_X0);
   localparam logic [15:0] BX1  = 16'(BOARD_X0 + 10 * CELL_PX);
   localparam logic [15:0] BY0  = 16'(BOARD_Y0);
   localparam logic [15:0] BY1  = 16'(BOARD_Y0 + 12 * CELL_PX);
   localparam logic [15:0] XMAX = 16'(LCD_W - 1);
   localparam logic [15:0] YMAX = 16'(LCD_H - 1);

   typedef enum logic [1:0] {ST_WAIT, ST_START, ST_SCAN} state_t;
   state_t state;

   logic [15:0] cnt_x, cnt_y;
   logic        issuing;
   logic [2:0]  snap_shape;
   logic [1:0]  snap_rot;
   logic [4:0]  snap_x;
   logic [5:0]  snap_y;
   logic [3:0]  snap_color;
   logic        s1_valid, s1_in_board, s1_border, s1_first, s1_last;

   function automatic logic [15:0] shape_mask(input logic [2:0] s);
      // bit index is row*4+col of the unrotated 4x4 box
      case (s)
         3'd0:    shape_mask = 16'h00F0;
         3'd1:    shape_mask = 16'h0033;
         3'd2:    shape_mask = 16'h0027;
         3'd3:    shape_mask = 16'h0036;
         3'd4:    shape_mask = 16'h0063;
         3'd5:    shape_mask = 16'h0071;
         default: shape_mask = 16'h0074;
      endcase
   endfunction

   function automatic logic [15:0] palette(input logic [3:0] i);
      case (i)
         4'd0:    palette = 16'h0000;
         4'd1:    palette = 16'hF800;
         4'd2:    palette = 16'h07E0;
         4'd3:    palette = 16'h001F;
         4'd4:    palette = 16'hFFE0;
         4'd5:    palette = 16'h07FF;
         4'd6:    palette = 16'hF81F;
         4'd7:    palette = 16'hFD20;
         4'd9:    palette = 16'hFFFF;
         default: palette = 16'h8410;
      endcase
   endfunction

   logic        adv, issue, in_x, in_y, bd_x, bd_y;
   logic [15:0] ix, iy, rx, ry;

   // Stage-1 input: START always issues pixel (0,0), SCAN issues from the counters.
   always_comb begin
      adv   = !pix_valid || pix_ready;
      ix    = (state == ST_START) ? 16'd0 : cnt_x;
      iy    = (state == ST_START) ? 16'd0 : cnt_y;
      issue = adv && ((state == ST_START) || (state == ST_SCAN && issuing));
      rx    = ix - BX0;
      ry    = iy - BY0;
      in_x  = (ix >= BX0) && (ix < BX1);
      in_y  = (iy >= BY0) && (iy < BY1);
      bd_x  = (ix + 16'd1 >= BX0) && (ix <= BX1);
      bd_y  = (iy + 16'd1 >= BY0) && (iy <= BY1);
   end

   logic [6:0]  dx, dy;
   logic [1:0]  sx, sy;
   logic [2:0]  shape_eff;
   logic [15:0] mask, color_n;
   logic        hit;
   logic [3:0]  idx;

   always_comb begin
      shape_eff = (snap_shape == 3'd7) ? 3'd6 : snap_shape;
      mask      = shape_mask(shape_eff);
      dx        = {2'b00, q_x} - {2'b00, snap_x};
      dy        = {2'b00, q_y} - {snap_y[5], snap_y};
      case (snap_rot)
         2'd0:    begin sx = dx[1:0];  sy = dy[1:0];  end
         2'd1:    begin sx = dy[1:0];  sy = ~dx[1:0]; end
         2'd2:    begin sx = ~dx[1:0]; sy = ~dy[1:0]; end
         default: begin sx = ~dy[1:0]; sy = dx[1:0];  end
      endcase
      hit     = (dx[6:2] == 5'd0) && (dy[6:2] == 5'd0) && mask[{sy, sx}];
      idx     = hit ? snap_color : q_color;
      color_n = 16'h0000;
      if (s1_in_board)    color_n = palette(idx);
      else if (s1_border) color_n = 16'h7BEF;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_WAIT;
         frame_start <= 1'b0;
         cnt_x       <= '0;
         cnt_y       <= '0;
         issuing     <= 1'b0;
         snap_shape  <= '0;
         snap_rot    <= '0;
         snap_x      <= '0;
         snap_y      <= '0;
         snap_color  <= '0;
         s1_valid    <= 1'b0;
         s1_in_board <= 1'b0;
         s1_border   <= 1'b0;
         s1_first    <= 1'b0;
         s1_last     <= 1'b0;
         q_x         <= '0;
         q_y         <= '0;
         pix_data    <= '0;
         pix_valid   <= 1'b0;
         pix_first   <= 1'b0;
         pix_last    <= 1'b0;
      end else begin
         case (state)
            ST_WAIT: if (lcd_ready) begin
               state       <= ST_START;
               frame_start <= 1'b1;
            end
            ST_START: begin
               frame_start <= 1'b0;
               snap_shape  <= cur_shape;
               snap_rot    <= cur_rot;
               snap_x      <= cur_x;
               snap_y      <= cur_y;
               snap_color  <= cur_color;
               state       <= ST_SCAN;
            end
            ST_SCAN: if (pix_valid && pix_ready && pix_last) begin
               state       <= lcd_ready ? ST_START : ST_WAIT;
               frame_start <= lcd_ready;
            end
            default: state <= ST_WAIT;
         endcase

         if (issue) begin
            if (ix == XMAX) begin
               cnt_x <= '0;
               cnt_y <= iy + 16'd1;
            end else begin
               cnt_x <= ix + 16'd1;
               cnt_y <= iy;
            end
            issuing <= !(ix == XMAX && iy == YMAX);
         end

         if (adv) begin
            s1_valid <= issue;
            if (issue) begin
               s1_in_board <= in_x && in_y;
               s1_border   <= bd_x && bd_y && !(in_x && in_y);
               s1_first    <= (ix == 16'd0) && (iy == 16'd0);
               s1_last     <= (ix == XMAX) && (iy == YMAX);
               q_x         <= (in_x && in_y) ? rx[SH +: 5] : 5'd0;
               q_y         <= (in_x && in_y) ? ry[SH +: 5] : 5'd0;
            end
            pix_valid <= s1_valid;
            pix_data  <= color_n;
            pix_first <= s1_valid && s1_first;
            pix_last  <= s1_valid && s1_last;
         end
      end
   end
endmodule

// File: tb/tb_tetris_lcd_renderer.sv
// Bench for tetris_lcd_renderer on a reduced panel: random board/piece/backpressure
// checked pixel-by-pixel against a coordinate-level reference model.
module tb_tetris_lcd_renderer;
   localparam int W  = 52;
   localparam int H  = 56;
   localparam int C  = 4;
   localparam int X0 = 4;
   localparam int Y0 = 3;
   localparam int N  = W * H;

   logic        clk, reset, lcd_ready, frame_start, pix_valid, pix_ready, pix_first, pix_last;
   logic [4:0]  q_x, q_y, cur_x;
   logic [3:0]  q_color, cur_color;
   logic [2:0]  cur_shape;
   logic [1:0]  cur_rot;
   logic [5:0]  cur_y;
   logic [15:0] pix_data;

   tetris_lcd_renderer #(
      .LCD_W(W), .LCD_H(H), .CELL_PX(C), .BOARD_X0(X0), .BOARD_Y0(Y0)
   ) dut (
      .clk(clk), .reset(reset), .lcd_ready(lcd_ready), .frame_start(frame_start),
      .q_x(q_x), .q_y(q_y), .q_color(q_color),
      .cur_shape(cur_shape), .cur_rot(cur_rot), .cur_x(cur_x), .cur_y(cur_y),
      .cur_color(cur_color), .pix_data(pix_data), .pix_valid(pix_valid),
      .pix_ready(pix_ready), .pix_first(pix_first), .pix_last(pix_last)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] board [0:9][0:11];
   always_comb begin
      q_color = 4'd0;
      if (q_x < 5'd10 && q_y < 5'd12) q_color = board[int'(q_x)][int'(q_y)];
   end

   int checks = 0, errors = 0;
   int cyc = 0, fs_count = 0, last_fs_cyc = 0, acc_idx = 0;
   bit rand_ready = 0, rand_board = 0;
   int sn_shape, sn_rot, sn_x, sn_y, sn_color;
   logic [15:0] exp_q[$];
   logic [15:0] got_frame [N];
   bit          prev_stall = 0;
   logic [15:0] prev_data;
   logic [12:0] prev_ctl;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // reference model
   function automatic bit occupied(int shape, int rot, int dx, int dy);
      int px, py;
      if (shape == 7) shape = 6;
      case (rot)
         0:       begin px = dx;     py = dy;     end
         1:       begin px = dy;     py = 3 - dx; end
         2:       begin px = 3 - dx; py = 3 - dy; end
         default: begin px = 3 - dy; py = dx;     end
      endcase
      case (shape)
         0:       return py == 1;
         1:       return px <= 1 && py <= 1;
         2:       return (py == 0 && px <= 2) || (py == 1 && px == 1);
         3:       return (py == 0 && px >= 1 && px <= 2) || (py == 1 && px <= 1);
         4:       return (py == 0 && px <= 1) || (py == 1 && px >= 1 && px <= 2);
         5:       return (py == 0 && px == 0) || (py == 1 && px <= 2);
         default: return (py == 0 && px == 2) || (py == 1 && px <= 2);
      endcase
   endfunction

   function automatic logic [15:0] rgb(int i);
      case (i)
         0: return 16'h0000;  1: return 16'hF800;  2: return 16'h07E0;
         3: return 16'h001F;  4: return 16'hFFE0;  5: return 16'h07FF;
         6: return 16'hF81F;  7: return 16'hFD20;  9: return 16'hFFFF;
         default: return 16'h8410;
      endcase
   endfunction

   function automatic logic [15:0] model_pixel(int x, int y);
      int bx = x - X0, by = y - Y0, cx, cy, dx, dy;
      if (bx >= 0 && bx < 10 * C && by >= 0 && by < 12 * C) begin
         cx = bx / C; cy = by / C;
         dx = cx - sn_x; dy = cy - sn_y;
         if (dx >= 0 && dx <= 3 && dy >= 0 && dy <= 3 && occupied(sn_shape, sn_rot, dx, dy))
            return rgb(sn_color);
         return rgb(int'(board[cx][cy]));
      end
      if (bx >= -1 && bx <= 10 * C && by >= -1 && by <= 12 * C) return 16'h7BEF;
      return 16'h0000;
   endfunction

   // driver tasks
   task automatic randomize_piece();
      cur_shape = 3'($urandom_range(0, 7));
      cur_rot   = 2'($urandom_range(0, 3));
      cur_x     = 5'($urandom_range(0, 9));
      cur_y     = 6'(int'($urandom_range(0, 14)) - 3);
      cur_color = 4'($urandom_range(1, 15));
   endtask

   task automatic on_frame_start();
      fs_count++;
      if (fs_count == 2) check("fs_period", cyc - last_fs_cyc, N + 2);
      last_fs_cyc = cyc;
      if (rand_board)
         for (int cx = 0; cx < 10; cx++)
            for (int cy = 0; cy < 12; cy++)
               board[cx][cy] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      sn_shape = int'(cur_shape); sn_rot = int'(cur_rot); sn_x = int'(cur_x);
      sn_y = int'($signed(cur_y)); sn_color = int'(cur_color);
      exp_q.delete();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) exp_q.push_back(model_pixel(x, y));
      acc_idx = 0;
   endtask

   // one clock: monitor at the falling edge, then choose pix_ready for the next rising edge
   task automatic cycle();
      @(negedge clk);
      cyc++;
      if (frame_start) on_frame_start();
      if (prev_stall) begin
         check("hold_data", pix_data, prev_data);
         check("hold_ctl", {pix_valid, pix_first, pix_last, q_x, q_y}, prev_ctl);
      end
      pix_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (pix_valid && pix_ready) begin
         check("pix_count", acc_idx < N, 1);
         if (exp_q.size() > 0) check("pix_data", pix_data, exp_q.pop_front());
         check("pix_first", pix_first, acc_idx == 0);
         check("pix_last", pix_last, acc_idx == N - 1);
         if (acc_idx < N) got_frame[acc_idx] = pix_data;
         acc_idx++;
      end
      prev_stall = pix_valid && !pix_ready;
      prev_data  = pix_data;
      prev_ctl   = {pix_valid, pix_first, pix_last, q_x, q_y};
   endtask

   task automatic wait_pix(input int target_fs, input int count, input int budget);
      int n = 0;
      while (!(fs_count >= target_fs && acc_idx >= count) && n < budget) begin
         cycle();
         n++;
      end
      check("wait_pix", (fs_count >= target_fs && acc_idx >= count), 1);
   endtask

   initial begin
      reset = 1'b1; lcd_ready = 1'b0; pix_ready = 1'b1;
      cur_shape = '0; cur_rot = '0; cur_x = '0; cur_y = '0; cur_color = '0;
      for (int cx = 0; cx < 10; cx++)
         for (int cy = 0; cy < 12; cy++) board[cx][cy] = 4'd0;
      repeat (4) cycle();
      reset = 1'b0;
      cycle();
      check("rst_valid", pix_valid, 0);
      check("rst_data", pix_data, 0);
      check("rst_flags", {frame_start, pix_first, pix_last}, 0);
      check("rst_q", {q_x, q_y}, 0);
      repeat (100) cycle();
      check("idle_fs", fs_count, 0);

      // frame 1: T piece at (3,0), board cell (9,11) = 4, no backpressure
      board[9][11] = 4'd4;
      cur_shape = 3'd2; cur_rot = 2'd0; cur_x = 5'd3; cur_y = 6'd0; cur_color = 4'd1;
      lcd_ready = 1'b1;
      cycle();
      check("fs_pulse", frame_start, 1);
      cycle();
      check("fs_width", frame_start, 0);
      check("s1_only", pix_valid, 0);
      cycle();
      check("first_valid", pix_valid, 1);
      check("first_flag", pix_first, 1);
      check("first_data", pix_data, 16'h0000);
      wait_pix(1, 100, 200);
      randomize_piece();
      rand_board = 1'b1;
      wait_pix(1, N, N + 10);
      check("spot_piece", got_frame[(Y0 + 2) * W + X0 + 3 * C + 2], 16'hF800);
      check("spot_empty", got_frame[(Y0 + C) * W + X0 + 3 * C], 16'h0000);
      check("spot_stem", got_frame[(Y0 + C) * W + X0 + 4 * C], 16'hF800);
      check("spot_cell911", got_frame[(Y0 + 12 * C - 1) * W + X0 + 10 * C - 1], 16'hFFE0);
      check("spot_border_r", got_frame[(Y0 + 12 * C - 1) * W + X0 + 10 * C], 16'h7BEF);
      check("spot_outside", got_frame[(Y0 + 12 * C - 1) * W + X0 + 10 * C + 1], 16'h0000);
      check("spot_corner", got_frame[(Y0 - 1) * W + X0 - 1], 16'h7BEF);

      // frame 2: random board and piece, random backpressure, lcd_ready dropped mid-frame
      rand_ready = 1'b1;
      wait_pix(2, N / 2, 4 * N);
      lcd_ready = 1'b0;
      randomize_piece();
      wait_pix(2, N, 4 * N);
      repeat (20) cycle();
      check("no_restart", fs_count, 2);
      check("idle_valid", pix_valid, 0);

      // frame 3 aborted by reset, frame 4 must restart cleanly from (0,0)
      lcd_ready = 1'b1;
      wait_pix(3, 200, 1000);
      reset = 1'b1;
      prev_stall = 1'b0;
      cycle();
      reset = 1'b0;
      check("abort_valid", pix_valid, 0);
      check("abort_flags", {frame_start, pix_first, pix_last}, 0);
      randomize_piece();
      wait_pix(4, N, 4 * N);
      check("fs_total", fs_count, 4);
      lcd_ready = 1'b0;
      repeat (10) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/tetris_lcd_renderer.md
# tetris_lcd_renderer

Pixel-stream renderer for the SPI LCD Tetris build. Sits directly downstream of the game logic. Each frame it walks the LCD raster and reads the locked board through the game's combinational board query port. It overlays the falling piece from a per-frame snapshot of the piece registers, maps colour indices to RGB565, and streams pixels to the SPI LCD driver over a valid/ready handshake. It also generates the `frame_start` pulse that paces the game.

## Interface
Parameters:
- `LCD_W`, default 240: panel width in pixels.
- `LCD_H`, default 240: panel height in pixels.
- `CELL_PX`, default 16: cell edge in pixels; must be a power of two.
- `BOARD_X0`, default 40: left pixel column of the board area.
- `BOARD_Y0`, default 24: top pixel row of the board area.

Ports:
- `clk`  in  1: system clock; the only clock.
- `reset`  in  1: synchronous, active-high reset.
- `lcd_ready`  in  1: LCD driver initialised and able to take a frame.
- `frame_start`  out  1: one-cycle pulse at the start of each frame.
- `q_x`  out  5: board query column (0..9).
- `q_y`  out  5: board query row (0..11).
- `q_color`  in  4: board cell colour, combinational from `q_x`/`q_y` in the same cycle; 0 means empty.
- `cur_shape`  in  3: falling piece shape (0..6; 7 is treated as 6).
- `cur_rot`  in  2: falling piece rotation.
- `cur_x`  in  5: left column of the piece's 4x4 bounding box.
- `cur_y`  in  6: top row of the bounding box; signed, -3..11.
- `cur_color`  in  4: falling piece colour index.
- `pix_data`  out  16: RGB565 pixel.
- `pix_valid`  out  1: `pix_data` is valid.
- `pix_ready`  in  1: driver accepts the pixel when `pix_valid` and `pix_ready` are both high.
- `pix_first`  out  1: marks pixel (0,0) of the frame.
- `pix_last`  out  1: marks pixel (`LCD_W`-1, `LCD_H`-1) of the frame.

## Operation
FSM has three states:
- WAIT: idle. Moves to START when `lcd_ready`=1.
- START: lasts one cycle.
  - `frame_start`=1.
  - Snapshots `cur_shape`, `cur_rot`, `cur_x`, `cur_y`, `cur_color` into internal registers.
  - Clears the raster counters.
  - Moves to SCAN.
- SCAN: issues raster coordinates x from 0 to `LCD_W`-1 (inner loop) and y from 0 to `LCD_H`-1 (outer loop).
  - When the last pixel is accepted: go to START if `lcd_ready`=1, else WAIT.
  - `lcd_ready` is ignored mid-frame.
  - Frames never overlap; the pipeline drains before the next START.

Pipeline, two stages, advancing only when `!pix_valid || pix_ready`:
- Stage 1 registers x, y, the region flags, the cell coordinates and the in-cell flag.
  - Cell coordinates: cx=(x-`BOARD_X0`)>>log2(`CELL_PX`), cy likewise from y.
  - `q_x`/`q_y` are the stage-1 cx/cy. They are 0 when the pixel is outside the board.
- Stage 2 registers `pix_data`, `pix_valid`, `pix_first`, `pix_last`.

Pixel colour rules:
- Board area (x in `BOARD_X0`..`BOARD_X0`+10*`CELL_PX`-1, y in `BOARD_Y0`..`BOARD_Y0`+12*`CELL_PX`-1):
  - Compute dx=cx-snap_x and dy=cy-snap_y as signed 7-bit values.
  - If dx and dy are both in 0..3 and the piece mask bit is set, the index is `snap_color`. The piece overrides the board.
  - Otherwise the index is `q_color`.
- Border: a one-pixel frame directly outside the board area. Colour 16'h7BEF.
- Anywhere else: 16'h0000.

Shape masks at rotation 0 (rows listed top to bottom, columns 0..3):
- 0 I: row 1, columns 0-3.
- 1 O: rows 0-1, columns 0-1.
- 2 T: row 0 columns 0-2; row 1 column 1.
- 3 S: row 0 columns 1-2; row 1 columns 0-1.
- 4 Z: row 0 columns 0-1; row 1 columns 1-2.
- 5 J: row 0 column 0; row 1 columns 0-2.
- 6 L: row 0 column 2; row 1 columns 0-2.

Rotation: occupied(dx,dy) = rot0(sx,sy), where (sx,sy) is:
- rot 0: (dx, dy).
- rot 1: (dy, 3-dx).
- rot 2: (3-dx, 3-dy).
- rot 3: (3-dy, dx).

Palette (index → RGB565):
- 0: 0000.
- 1: F800.
- 2: 07E0.
- 3: 001F.
- 4: FFE0.
- 5: 07FF.
- 6: F81F.
- 7: FD20.
- 8: 8410.
- 9: FFFF.
- 10-15: 8410.

## Timing
- Reset values: every output 0. FSM in WAIT; snapshot registers and counters cleared. Reset mid-frame aborts the frame immediately; `pix_valid` is 0 on the next cycle.
- START lasts one cycle.
- Stage 1 holds pixel (0,0) in the cycle after START. `pix_valid` with pixel (0,0) is asserted 2 cycles after the `frame_start` pulse.
- With `pix_ready` tied to 1: one pixel per cycle, and the frame_start period is `LCD_W`*`LCD_H`+2 cycles (57602 with default parameters).
- Backpressure:
  - While `pix_valid` && !`pix_ready`: `pix_data`, `pix_first`, `pix_last`, `q_x`, `q_y` hold, and the counters freeze.
  - `q_color` is resampled every cycle from the stable `q_x`/`q_y`, which is harmless.
- Piece changes made by the game during a frame are not visible until the next START.

## Test plan
- Reset with `lcd_ready`=0 for 100 cycles, then raise it → `frame_start` pulses 1 cycle later; first `pix_valid` with `pix_first`=1 and `pix_data`=0000 exactly 2 cycles after the pulse.
- `pix_ready`=1 throughout → consecutive `frame_start` pulses 57602 cycles apart; 57600 accepted pixels per frame; `pix_last` only on the final one.
- Empty board, snapshot shape=2, rot=0, x=3, y=0, color=1 → pixel (BOARD_X0+3*16+5, BOARD_Y0+5) = F800; pixel (BOARD_X0+3*16, BOARD_Y0+16) = 0000; pixel (BOARD_X0+4*16, BOARD_Y0+16) = F800.
- Board model returns 4 at cell (9,11) → pixel (199,215) = FFE0; pixel (200,215) = 7BEF; pixel (201,215) = 0000.
- Random `pix_ready` toggling → output sequence identical to the ready=1 run; no pixel dropped or duplicated; held data stable while stalled.
- Assert `reset` in mid-SCAN for 1 cycle → `pix_valid`=0 next cycle; a fresh frame starts from (0,0) once `lcd_ready`=1.
